// File: rtl/rr_bus_mux.sv
// rr_bus_mux: forwards the arbiter-granted master's request to one shared slave and acks it
module rr_bus_mux #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          gnt,
  input  logic [4*ADDR_W-1:0] m_addr,
  input  logic [4*DATA_W-1:0] m_wdata,
  input  logic [3:0]          m_we,
  output logic [3:0]          m_ack,
  output logic                m_err,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic                s_we,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                gnt_err,
  output logic                busy
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, ACK} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] idx, gnt_idx;
  logic err, gnt_one, gnt_multi;
  always_comb begin
    gnt_idx = 2'd0;
    for (int i = 0; i < 4; i++) gnt_idx = gnt[i] ? 2'(i) : gnt_idx;
  end
  assign gnt_multi = (gnt & (gnt - 4'd1)) != 4'd0;
  assign gnt_one   = gnt != 4'd0 && !gnt_multi;
  assign s_valid   = state == ISSUE;
  assign busy      = state != IDLE;
  assign m_ack     = state == ACK ? 4'd1 << idx : 4'd0;
  assign m_err     = state == ACK && err;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_we    <= 1'b0;
      cnt     <= '0;
      err     <= 1'b0;
      m_rdata <= '0;
      gnt_err <= 1'b0;
    end else begin
      gnt_err <= state == IDLE && gnt_multi;
      case (state)
        IDLE: if (gnt_one) begin
          idx     <= gnt_idx;
          s_addr  <= m_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          s_wdata <= m_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
          s_we    <= m_we[gnt_idx];
          state   <= ISSUE;
        end
        ISSUE: if (s_ready) begin
          cnt   <= '0;
          err   <= 1'b0;
          state <= s_we ? ACK : WAIT_RESP;
        end
        WAIT_RESP: if (s_rvalid) begin
          m_rdata <= s_rdata;
          state   <= ACK;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          err   <= 1'b1;
          state <= ACK;
        end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule
